// File: rtl/wb_regfile.sv
// Write-back select plus 32-entry architectural register file with two
// combinational read ports and same-cycle write-through bypass.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWrite_i,
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] dataMem_data_i,
    input  logic [DATA_W-1:0] ALU_result_i,
    input  logic [ADDR_W-1:0] RDaddr_i,
    input  logic [ADDR_W-1:0] RSaddr_i,
    input  logic [ADDR_W-1:0] RTaddr_i,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] WBdata_o,
    output logic              WBvalid_o
);

    localparam int NumRegs = 1 << ADDR_W;

    logic [DATA_W-1:0] regArray [NumRegs];

    assign WBdata_o  = MemtoReg_i ? dataMem_data_i : ALU_result_i;
    assign WBvalid_o = rst_i & RegWrite_i & (RDaddr_i != '0);

    // Reset wins over commit; entry 0 is never written, so it stays zero.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                regArray[i] <= '0;
            end
        end else if (WBvalid_o) begin
            regArray[RDaddr_i] <= WBdata_o;
        end
    end

    function automatic logic [DATA_W-1:0] readPort(
        input logic              rstN,
        input logic [ADDR_W-1:0] addr,
        input logic              wbValid,
        input logic [ADDR_W-1:0] wbAddr,
        input logic [DATA_W-1:0] wbData,
        input logic [DATA_W-1:0] arrayData
    );
        if (!rstN || addr == '0) begin
            return '0;
        end else if (wbValid && addr == wbAddr) begin
            return wbData;
        end else begin
            return arrayData;
        end
    endfunction

    always_comb begin
        RSdata_o = readPort(rst_i, RSaddr_i, WBvalid_o, RDaddr_i, WBdata_o, regArray[RSaddr_i]);
        RTdata_o = readPort(rst_i, RTaddr_i, WBvalid_o, RDaddr_i, WBdata_o, regArray[RTaddr_i]);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed-vector bench for wb_regfile: inputs change on the falling edge,
// outputs are sampled shortly after, commits happen on the rising edge.
module tb_wb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst_i;
    logic              RegWrite_i;
    logic              MemtoReg_i;
    logic [DATA_W-1:0] dataMem_data_i;
    logic [DATA_W-1:0] ALU_result_i;
    logic [ADDR_W-1:0] RDaddr_i;
    logic [ADDR_W-1:0] RSaddr_i;
    logic [ADDR_W-1:0] RTaddr_i;
    logic [DATA_W-1:0] RSdata_o;
    logic [DATA_W-1:0] RTdata_o;
    logic [DATA_W-1:0] WBdata_o;
    logic              WBvalid_o;

    int checks = 0;
    int errors = 0;

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .RegWrite_i    (RegWrite_i),
        .MemtoReg_i    (MemtoReg_i),
        .dataMem_data_i(dataMem_data_i),
        .ALU_result_i  (ALU_result_i),
        .RDaddr_i      (RDaddr_i),
        .RSaddr_i      (RSaddr_i),
        .RTaddr_i      (RTaddr_i),
        .RSdata_o      (RSdata_o),
        .RTdata_o      (RTdata_o),
        .WBdata_o      (WBdata_o),
        .WBvalid_o     (WBvalid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic setWb(input logic we, input logic [ADDR_W-1:0] rd, input logic [31:0] alu,
                         input logic [31:0] mem, input logic m2r);
        RegWrite_i     = we;
        RDaddr_i       = rd;
        ALU_result_i   = alu;
        dataMem_data_i = mem;
        MemtoReg_i     = m2r;
    endtask

    task automatic setRead(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt);
        RSaddr_i = rs;
        RTaddr_i = rt;
        #1;
    endtask

    // One rising edge, then return on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_i = 1'b0;
        setWb(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        RSaddr_i = '0;
        RTaddr_i = '0;
        step();
        step();

        // Reset state, with a would-be write and bypass pending on r4.
        setWb(1'b1, 5'd4, 32'h44, 32'h99, 1'b0);
        setRead(5'd4, 5'd4);
        checkVal("rst_rs", RSdata_o, 32'h0);
        checkVal("rst_rt", RTdata_o, 32'h0);
        checkVal("rst_valid", {31'b0, WBvalid_o}, 32'h0);
        checkVal("rst_wbdata", WBdata_o, 32'h44);
        step();

        // Reset priority: the r4 write at the reset edge must be lost.
        rst_i = 1'b1;
        setWb(1'b0, 5'd4, 32'h44, 32'h0, 1'b0);
        setRead(5'd4, 5'd4);
        checkVal("rstprio_r4", RSdata_o, 32'h0);

        // Mux select: ALU result, then memory word.
        setWb(1'b1, 5'd3, 32'h11, 32'h22, 1'b0);
        setRead(5'd0, 5'd0);
        checkVal("mux_alu_wb", WBdata_o, 32'h11);
        step();
        setWb(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        setRead(5'd3, 5'd0);
        checkVal("mux_alu_r3", RSdata_o, 32'h11);
        setWb(1'b1, 5'd3, 32'h11, 32'h22, 1'b1);
        setRead(5'd0, 5'd0);
        checkVal("mux_mem_wb", WBdata_o, 32'h22);
        step();
        setWb(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        setRead(5'd0, 5'd3);
        checkVal("mux_mem_r3", RTdata_o, 32'h22);

        // Bypass on both ports in the same cycle.
        setWb(1'b1, 5'd7, 32'hCAFE0001, 32'h0, 1'b0);
        setRead(5'd7, 5'd7);
        checkVal("byp_rs", RSdata_o, 32'hCAFE0001);
        checkVal("byp_rt", RTdata_o, 32'hCAFE0001);
        checkVal("byp_valid", {31'b0, WBvalid_o}, 32'h1);
        step();
        setWb(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        setRead(5'd7, 5'd3);
        checkVal("byp_r7_after", RSdata_o, 32'hCAFE0001);
        checkVal("r3_hold", RTdata_o, 32'h22);

        // r0 protection.
        setWb(1'b1, 5'd0, 32'hFFFFFFFF, 32'h0, 1'b0);
        setRead(5'd0, 5'd0);
        checkVal("r0_rs", RSdata_o, 32'h0);
        checkVal("r0_valid", {31'b0, WBvalid_o}, 32'h0);
        step();
        setWb(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        setRead(5'd0, 5'd0);
        checkVal("r0_after", RTdata_o, 32'h0);

        // RegWrite low must neither bypass nor commit.
        setWb(1'b1, 5'd9, 32'h5, 32'h0, 1'b0);
        step();
        setWb(1'b0, 5'd9, 32'h6, 32'h0, 1'b0);
        setRead(5'd9, 5'd9);
        checkVal("nowe_rs", RSdata_o, 32'h5);
        checkVal("nowe_valid", {31'b0, WBvalid_o}, 32'h0);
        step();
        setRead(5'd9, 5'd9);
        checkVal("nowe_after", RTdata_o, 32'h5);

        // Back-to-back writes to r10: later value wins, bypass tracks current.
        setWb(1'b1, 5'd10, 32'hA, 32'h0, 1'b0);
        step();
        setWb(1'b1, 5'd10, 32'hB, 32'h0, 1'b0);
        setRead(5'd10, 5'd9);
        checkVal("b2b_byp", RSdata_o, 32'hB);
        checkVal("b2b_other", RTdata_o, 32'h5);
        step();
        setWb(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        setRead(5'd10, 5'd10);
        checkVal("b2b_final", RSdata_o, 32'hB);

        // Reset clears the array.
        setWb(1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 1'b0);
        step();
        setWb(1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        setRead(5'd5, 5'd3);
        checkVal("clr_pre_r5", RSdata_o, 32'hDEADBEEF);
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        setRead(5'd5, 5'd3);
        checkVal("clr_r5", RSdata_o, 32'h0);
        checkVal("clr_r3", RTdata_o, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
